// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, byte-lane width,
// fault code and the word-index helper.
package riscv_mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int  BE_W      = 4;
    localparam logic RSP_FAULT = 1'b1;

    // Unsigned 32-bit wrap makes addresses below the base land far out of range.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store requester (master) and the responder (slave).
interface dmem_responder_if;
    import riscv_mem_pkg::*;

    // Both channels: a transfer happens on a rising edge where valid and ready are both high;
    // the sender holds its payload stable from raising valid until that edge.
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [BE_W-1:0] req_be;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [BE_W-1:0] be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    // No reset: contents survive rst_n so an aborted transaction leaves old data visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, LATENCY wait cycles, then a held response.
// The array is written and load data captured on the edge that enters RESP.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus,
    output state_t            dbg_state
);
    localparam int unsigned CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam int unsigned IDX_W = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q;
    logic             accept, commit, fault;
    logic             we_q, err_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [BE_W-1:0]  be_q;
    logic             cur_we;
    logic [31:0]      cur_addr, cur_wdata, word_idx, arr_rdata;
    logic [BE_W-1:0]  cur_be;

    assign accept = bus.req_valid && ready_q;

    // With LATENCY==0 the commit happens on the accept edge, so live inputs are used in IDLE.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state_q == ST_IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
            cur_be    = bus.req_be;
        end
        word_idx = word_index(cur_addr, BASE_ADDR);
        fault    = (cur_addr[1:0] != 2'b00) || (word_idx >= DEPTH_WORDS);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
            if (commit) begin
                rdata_q <= (cur_we || fault) ? 32'h0 : arr_rdata;
                err_q   <= fault ? RSP_FAULT : 1'b0;
            end else if (state_q == ST_RESP && bus.rsp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .wr_en (commit && cur_we && !fault),
        .be    (cur_be),
        .idx   (word_idx[IDX_W-1:0]),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state_q;
endmodule
